// File: rtl/aemb2_dec_mt.sv
// AEMB2 multi-thread decode / operand-fetch stage: decodes the fetched word, latches
// forwarded operands into OF, tracks IMM prefixes per thread and flags same-thread hazards.
module aemb2_dec_mt #(
  parameter int THREADS = 2,
  parameter int FWD_MX  = 1,
  parameter int CNT_W   = 16,
  localparam int TW     = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic             gclk,
  input  logic             grst,
  input  logic             dena,
  input  logic [31:0]      ich_dat,
  input  logic [TW-1:0]    tid_if,
  input  logic [29:0]      rpc_if,
  input  logic [31:0]      opa_if,
  input  logic [31:0]      opb_if,
  input  logic [31:0]      opd_if,
  input  logic [31:0]      alu_ex,
  input  logic [31:0]      res_mx,
  input  logic [1:0]       bra_ex,
  input  logic [TW-1:0]    tid_ex,
  output logic [31:0]      opa_of,
  output logic [31:0]      opb_of,
  output logic [31:0]      opd_of,
  output logic [5:0]       opc_of,
  output logic [4:0]       ra_of,
  output logic [4:0]       rd_of,
  output logic [15:0]      imm_of,
  output logic [TW-1:0]    tid_of,
  output logic [2:0]       mux_of,
  output logic [2:0]       mux_ex,
  output logic [4:0]       rd_ex,
  output logic             hzd_bpc,
  output logic             hzd_fwd,
  output logic [CNT_W-1:0] hzd_cnt
);

  typedef enum logic [2:0] {
    MX_NOP = 3'd0,
    MX_ALU = 3'd1,
    MX_RPC = 3'd2,
    MX_MEM = 3'd4,
    MX_MUL = 3'd5,
    MX_BSF = 3'd6,
    MX_SFR = 3'd7
  } mux_t;

  logic [5:0]  opc;
  logic [4:0]  rd, ra, rb, sd;
  logic [15:0] imm;
  logic        is_bru, is_bcc, is_rtd, is_imm, is_str, is_lod, is_get, is_mov, is_mul, is_bsf;
  logic        use_a, use_b, use_d;
  mux_t        mux_dec;

  assign opc = ich_dat[31:26];
  assign rd  = ich_dat[25:21];
  assign ra  = ich_dat[20:16];
  assign imm = ich_dat[15:0];
  assign rb  = imm[15:11];

  assign is_bru = (opc == 6'o46) || (opc == 6'o56);
  assign is_bcc = (opc == 6'o47) || (opc == 6'o57);
  assign is_rtd = (opc == 6'o55);
  assign is_imm = (opc == 6'o54);
  assign is_get = (opc == 6'o33);
  assign is_mov = (opc == 6'o45);
  assign is_str = (opc[5:4] == 2'b11) &&  opc[2];
  assign is_lod = (opc[5:4] == 2'b11) && !opc[2];
  assign is_mul = (opc[5:4] == 2'b01) && (opc[2:0] == 3'd0);
  assign is_bsf = (opc[5:4] == 2'b01) && (opc[2:0] == 3'd1);

  // BCC tests ra through the opd path, so opa is free to carry the PC
  assign sd    = is_bcc ? ra : rd;
  assign use_a = !(is_bru || is_bcc || is_imm);
  assign use_b = !opc[3];
  assign use_d = is_bcc || is_str;

  always_comb begin
    mux_dec = MX_ALU;
    if (is_str || is_rtd || is_bcc)  mux_dec = MX_NOP;
    else if (is_lod || is_get)       mux_dec = MX_MEM;
    else if (is_mov)                 mux_dec = MX_SFR;
    else if (is_mul)                 mux_dec = MX_MUL;
    else if (is_bsf)                 mux_dec = MX_BSF;
    else if (is_bru)                 mux_dec = MX_RPC;
  end

  // Downstream copies of the OF instruction used for forwarding
  logic [TW-1:0] tid_xs, tid_mx;
  logic [4:0]    rd_mx;
  logic [2:0]    mux_mx;
  logic          wrb_ex, wrb_mx;

  assign wrb_ex = (rd_ex != 5'd0) && (mux_ex != MX_NOP);
  assign wrb_mx = (rd_mx != 5'd0) && (mux_mx != MX_NOP);

  function automatic logic hit(input logic [4:0] s, input logic [4:0] rdx,
                               input logic wrbx, input logic [TW-1:0] tidx,
                               input logic [TW-1:0] tidc);
    return (s == rdx) && wrbx && (tidx == tidc);
  endfunction

  function automatic logic [31:0] fwd(input logic ex_hit, input logic mx_hit,
                                      input logic ex_alu, input logic [31:0] alu,
                                      input logic [31:0] res, input logic [31:0] rf);
    if (ex_hit && ex_alu)                    return alu;
    else if (FWD_MX != 0 && mx_hit && !ex_hit) return res;
    else                                     return rf;
  endfunction

  logic ex_a, ex_b, ex_d, mx_a, mx_b, mx_d;
  assign ex_a = hit(ra, rd_ex, wrb_ex, tid_xs, tid_if);
  assign ex_b = hit(rb, rd_ex, wrb_ex, tid_xs, tid_if);
  assign ex_d = hit(sd, rd_ex, wrb_ex, tid_xs, tid_if);
  assign mx_a = hit(ra, rd_mx, wrb_mx, tid_mx, tid_if);
  assign mx_b = hit(rb, rd_mx, wrb_mx, tid_mx, tid_if);
  assign mx_d = hit(sd, rd_mx, wrb_mx, tid_mx, tid_if);

  assign hzd_fwd = mux_ex[2] && ((use_a && ex_a) || (use_b && ex_b) || (use_d && ex_d));
  assign hzd_bpc = (bra_ex == 2'b10) && ((THREADS == 1) || (tid_ex == tid_if));

  logic squash;
  assign squash = hzd_fwd || hzd_bpc;

  // Per-thread IMM prefix state
  logic [THREADS-1:0] imm_f;
  logic [15:0]        imm_h [THREADS];
  logic [31:0]        imm32;

  assign imm32 = imm_f[tid_if] ? {imm_h[tid_if], imm} : {{16{imm[15]}}, imm};

  logic [31:0] opa_nx, opb_nx, opd_nx;
  assign opa_nx = (is_bru || is_bcc) ? {rpc_if, 2'b00}
                : fwd(ex_a, mx_a, !mux_ex[2], alu_ex, res_mx, opa_if);
  assign opb_nx = opc[3] ? imm32
                : fwd(ex_b, mx_b, !mux_ex[2], alu_ex, res_mx, opb_if);
  assign opd_nx = fwd(ex_d, mx_d, !mux_ex[2], alu_ex, res_mx, is_bcc ? opa_if : opd_if);

  always_ff @(posedge gclk) begin
    if (grst) begin
      opa_of  <= '0;
      opb_of  <= '0;
      opd_of  <= '0;
      opc_of  <= '0;
      ra_of   <= '0;
      rd_of   <= '0;
      imm_of  <= '0;
      tid_of  <= '0;
      mux_of  <= '0;
      mux_ex  <= '0;
      rd_ex   <= '0;
      tid_xs  <= '0;
      mux_mx  <= '0;
      rd_mx   <= '0;
      tid_mx  <= '0;
      hzd_cnt <= '0;
      imm_f   <= '0;
      for (int unsigned t = 0; t < THREADS; t++) imm_h[t] <= '0;
    end else if (dena) begin
      opa_of <= opa_nx;
      opb_of <= opb_nx;
      opd_of <= opd_nx;
      ra_of  <= ra;
      imm_of <= imm;
      tid_of <= tid_if;
      mux_ex <= mux_of;
      rd_ex  <= rd_of;
      tid_xs <= tid_of;
      mux_mx <= mux_ex;
      rd_mx  <= rd_ex;
      tid_mx <= tid_xs;
      if (squash) begin
        opc_of <= 6'o42;
        mux_of <= MX_NOP;
        rd_of  <= '0;
        if (hzd_cnt != '1) hzd_cnt <= hzd_cnt + 1'b1;
      end else begin
        opc_of <= opc;
        mux_of <= mux_dec;
        rd_of  <= rd;
        imm_f[tid_if] <= is_imm;
        if (is_imm) imm_h[tid_if] <= imm;
      end
    end
  end

endmodule

// File: tb/tb_aemb2_dec_mt.sv
// Directed bench for aemb2_dec_mt: IMM prefixes, same-thread forwarding, hazards and counter saturation.
module tb_aemb2_dec_mt;

  logic        gclk = 1'b0;
  logic        grst, dena;
  logic [31:0] ich_dat, opa_if, opb_if, opd_if, alu_ex, res_mx;
  logic [0:0]  tid_if, tid_ex;
  logic [29:0] rpc_if;
  logic [1:0]  bra_ex;

  logic [31:0] opa_of, opb_of, opd_of;
  logic [5:0]  opc_of;
  logic [4:0]  ra_of, rd_of, rd_ex;
  logic [15:0] imm_of, hzd_cnt;
  logic [0:0]  tid_of;
  logic [2:0]  mux_of, mux_ex;
  logic        hzd_bpc, hzd_fwd;

  logic [31:0] w_opa, w_opb, w_opd;
  logic [5:0]  w_opc;
  logic [4:0]  w_ra, w_rd, w_rdx;
  logic [15:0] w_imm;
  logic [0:0]  w_tid;
  logic [2:0]  w_mux, w_muxx;
  logic        w_bpc, w_fwd;
  logic [3:0]  cnt4;

  int total = 0;
  int bad   = 0;

  always #5 gclk = ~gclk;

  aemb2_dec_mt #(.THREADS(2), .FWD_MX(1), .CNT_W(16)) dut (
    .gclk(gclk), .grst(grst), .dena(dena), .ich_dat(ich_dat), .tid_if(tid_if),
    .rpc_if(rpc_if), .opa_if(opa_if), .opb_if(opb_if), .opd_if(opd_if),
    .alu_ex(alu_ex), .res_mx(res_mx), .bra_ex(bra_ex), .tid_ex(tid_ex),
    .opa_of(opa_of), .opb_of(opb_of), .opd_of(opd_of), .opc_of(opc_of),
    .ra_of(ra_of), .rd_of(rd_of), .imm_of(imm_of), .tid_of(tid_of),
    .mux_of(mux_of), .mux_ex(mux_ex), .rd_ex(rd_ex),
    .hzd_bpc(hzd_bpc), .hzd_fwd(hzd_fwd), .hzd_cnt(hzd_cnt)
  );

  aemb2_dec_mt #(.THREADS(2), .FWD_MX(1), .CNT_W(4)) dut4 (
    .gclk(gclk), .grst(grst), .dena(dena), .ich_dat(ich_dat), .tid_if(tid_if),
    .rpc_if(rpc_if), .opa_if(opa_if), .opb_if(opb_if), .opd_if(opd_if),
    .alu_ex(alu_ex), .res_mx(res_mx), .bra_ex(bra_ex), .tid_ex(tid_ex),
    .opa_of(w_opa), .opb_of(w_opb), .opd_of(w_opd), .opc_of(w_opc),
    .ra_of(w_ra), .rd_of(w_rd), .imm_of(w_imm), .tid_of(w_tid),
    .mux_of(w_mux), .mux_ex(w_muxx), .rd_ex(w_rdx),
    .hzd_bpc(w_bpc), .hzd_fwd(w_fwd), .hzd_cnt(cnt4)
  );

  localparam logic [5:0] ADD = 6'o00, ADDI = 6'o10, IMM = 6'o54, LW = 6'o62;

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] d,
                                      input logic [4:0] a, input logic [15:0] i);
    return {op, d, a, i};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] w, input logic [0:0] t);
    ich_dat = w;
    tid_if  = t;
    @(posedge gclk);
    #1;
  endtask

  initial begin
    grst = 1'b1; dena = 1'b1; ich_dat = '0; tid_if = '0; tid_ex = '0;
    rpc_if = 30'h0000_0100; opa_if = '0; opb_if = '0; opd_if = '0;
    alu_ex = '0; res_mx = '0; bra_ex = 2'b00;
    repeat (2) @(posedge gclk);
    #1 grst = 1'b0;

    chk("rst_opa", opa_of, 32'h0);
    chk("rst_opc", {26'd0, opc_of}, 32'h0);
    chk("rst_mux", {29'd0, mux_of}, 32'h0);
    chk("rst_cnt", {16'd0, hzd_cnt}, 32'h0);

    step(ins(ADDI, 5'd3, 5'd0, 16'hFFFF), 1'b0);
    chk("t1_opb", opb_of, 32'hFFFF_FFFF);
    chk("t1_mux", {29'd0, mux_of}, 32'd1);
    chk("t1_rd",  {27'd0, rd_of}, 32'd3);
    chk("t1_cnt", {16'd0, hzd_cnt}, 32'd0);

    step(ins(IMM, 5'd0, 5'd0, 16'h1234), 1'b0);
    step(ins(ADDI, 5'd4, 5'd0, 16'h5678), 1'b0);
    chk("t2_pref", opb_of, 32'h1234_5678);
    step(ins(ADDI, 5'd4, 5'd0, 16'h0001), 1'b0);
    chk("t2_clr", opb_of, 32'h0000_0001);

    step(ins(IMM, 5'd0, 5'd0, 16'hABCD), 1'b0);
    step(ins(ADDI, 5'd4, 5'd0, 16'h8000), 1'b1);
    chk("t3_oth", opb_of, 32'hFFFF_8000);
    step(ins(ADDI, 5'd4, 5'd0, 16'h0002), 1'b0);
    chk("t3_own", opb_of, 32'hABCD_0002);

    alu_ex = 32'hDEAD_BEEF; opa_if = 32'h0BAD_F00D;
    step(ins(ADD, 5'd5, 5'd0, 16'h0000), 1'b1);
    step(ins(ADDI, 5'd0, 5'd0, 16'h0000), 1'b0);
    chk("t4_rdex",  {27'd0, rd_ex}, 32'd5);
    chk("t4_muxex", {29'd0, mux_ex}, 32'd1);
    step(ins(ADD, 5'd9, 5'd5, 16'h0000), 1'b1);
    chk("t4_fwd", opa_of, 32'hDEAD_BEEF);
    step(ins(ADD, 5'd5, 5'd0, 16'h0000), 1'b1);
    step(ins(ADDI, 5'd0, 5'd0, 16'h0000), 1'b0);
    step(ins(ADD, 5'd9, 5'd5, 16'h0000), 1'b0);
    chk("t4_nofwd", opa_of, 32'h0BAD_F00D);

    opa_if = '0; res_mx = 32'h1111_2222;
    step(ins(LW, 5'd7, 5'd0, 16'h0000), 1'b0);
    step(ins(ADDI, 5'd0, 5'd0, 16'h0000), 1'b1);
    ich_dat = ins(ADD, 5'd8, 5'd7, 16'h0000); tid_if = 1'b0;
    #1 chk("t5_hzd", {31'd0, hzd_fwd}, 32'd1);
    chk("t5_bpc0", {31'd0, hzd_bpc}, 32'd0);
    @(posedge gclk); #1;
    chk("t5_opc", {26'd0, opc_of}, 32'o42);
    chk("t5_mux", {29'd0, mux_of}, 32'd0);
    chk("t5_rd",  {27'd0, rd_of}, 32'd0);
    chk("t5_cnt", {16'd0, hzd_cnt}, 32'd1);
    step(ins(ADD, 5'd8, 5'd7, 16'h0000), 1'b0);
    chk("t5_mxfwd", opa_of, 32'h1111_2222);
    chk("t5_rtrd",  {27'd0, rd_of}, 32'd8);

    dena = 1'b0; bra_ex = 2'b10; tid_ex = 1'b0;
    ich_dat = ins(ADDI, 5'd6, 5'd0, 16'h0009); tid_if = 1'b0;
    #1 chk("hold_bpc", {31'd0, hzd_bpc}, 32'd1);
    @(posedge gclk); #1;
    chk("hold_cnt", {16'd0, hzd_cnt}, 32'd1);
    chk("hold_opc", {26'd0, opc_of}, 32'o00);
    dena = 1'b1;

    tid_ex = 1'b1;
    ich_dat = ins(IMM, 5'd0, 5'd0, 16'h7777); tid_if = 1'b1;
    #1 chk("t6_bpc", {31'd0, hzd_bpc}, 32'd1);
    @(posedge gclk); #1;
    chk("t6_opc", {26'd0, opc_of}, 32'o42);
    chk("t6_cnt", {16'd0, hzd_cnt}, 32'd2);
    chk("t6_cnt4", {28'd0, cnt4}, 32'd2);
    bra_ex = 2'b00;
    step(ins(ADDI, 5'd4, 5'd0, 16'h9000), 1'b1);
    chk("t6_sext", opb_of, 32'hFFFF_9000);

    bra_ex = 2'b10; tid_ex = 1'b0;
    ich_dat = ins(ADDI, 5'd4, 5'd0, 16'h0005); tid_if = 1'b1;
    #1 chk("t6_othtid", {31'd0, hzd_bpc}, 32'd0);
    step(ins(ADDI, 5'd4, 5'd0, 16'h0005), 1'b1);
    chk("t6_pass", opb_of, 32'h0000_0005);
    chk("t6_cnt_same", {16'd0, hzd_cnt}, 32'd2);

    for (int i = 0; i < 20; i++) step(ins(ADDI, 5'd4, 5'd0, 16'h0001), 1'b0);
    chk("sat_cnt16", {16'd0, hzd_cnt}, 32'd22);
    chk("sat_cnt4",  {28'd0, cnt4}, 32'hF);
    bra_ex = 2'b00;

    step(ins(IMM, 5'd0, 5'd0, 16'h5555), 1'b0);
    grst = 1'b1;
    @(posedge gclk); #1;
    grst = 1'b0;
    chk("mrst_cnt", {16'd0, hzd_cnt}, 32'd0);
    step(ins(ADDI, 5'd4, 5'd0, 16'h0003), 1'b0);
    chk("mrst_sext", opb_of, 32'h0000_0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
